// File: rtl/pwm_duty_ramp_pkg.sv
// Shared definitions for the PWM duty ramp and the PWM stage: ramp FSM encoding and period length.
package pwm_duty_ramp_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StUp   = 2'd1,
    StDown = 2'd2
  } ramp_state_e;

  // A PWM period spans terminal count + 1 clocks.
  function automatic int unsigned period_len(input int unsigned periodo);
    return periodo + 1;
  endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running period counter 0..Periodo with a registered last-clock-of-period pulse.
module pwm_period_timer
  import pwm_duty_ramp_pkg::*;
#(
  parameter int unsigned Bits_counter = 8,
  parameter int unsigned Periodo      = 250
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic wrap_o,
  output logic period_tick_o
);

  localparam int unsigned PeriodLen = period_len(Periodo);
  localparam logic [Bits_counter-1:0] TermCnt = Bits_counter'(PeriodLen - 1);

  logic [Bits_counter-1:0] cnt_q, cnt_d;
  logic                    tick_q;

  always_comb begin
    cnt_d = (cnt_q == TermCnt) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      // Registered so the pulse lines up with the cycle the counter holds the terminal count.
      tick_q <= (cnt_d == TermCnt);
    end
  end

  assign wrap_o        = (cnt_q == TermCnt);
  assign period_tick_o = tick_q;

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slews the PWM duty toward an accepted target by at most one step per PWM period.
module pwm_duty_ramp
  import pwm_duty_ramp_pkg::*;
#(
  parameter int unsigned Bits_counter = 8,
  parameter int unsigned Periodo      = 250
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    target_valid_i,
  output logic                    target_ready_o,
  input  logic [Bits_counter-1:0] target_duty_i,
  input  logic [Bits_counter-1:0] step_i,
  input  logic                    hold_i,
  output logic [Bits_counter-1:0] duty_cycle_o,
  output logic                    period_tick_o,
  output logic                    at_target_o
);

  localparam logic [Bits_counter-1:0] PeriodoC = Bits_counter'(Periodo);

  ramp_state_e             state_q, state_d;
  logic [Bits_counter-1:0] duty_q, duty_d;
  logic [Bits_counter-1:0] target_q, target_d;
  logic                    at_target_q;
  logic                    rst_seen_q;

  logic                    wrap;
  logic                    accept;
  logic                    update;
  logic [Bits_counter-1:0] target_clamped;
  logic [Bits_counter:0]   diff_up, diff_dn, step_ext, sum_up, sum_dn;

  pwm_period_timer #(
    .Bits_counter (Bits_counter),
    .Periodo      (Periodo)
  ) u_timer (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .wrap_o        (wrap),
    .period_tick_o (period_tick_o)
  );

  assign target_ready_o = rst_seen_q && !hold_i;
  assign accept         = target_valid_i && target_ready_o;
  assign update         = wrap && !hold_i;
  assign target_clamped = (target_duty_i > PeriodoC) ? PeriodoC : target_duty_i;

  assign step_ext = {1'b0, step_i};
  assign diff_up  = {1'b0, target_q} - {1'b0, duty_q};
  assign diff_dn  = {1'b0, duty_q} - {1'b0, target_q};
  assign sum_up   = {1'b0, duty_q} + step_ext;
  assign sum_dn   = {1'b0, duty_q} - step_ext;

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = accept ? target_clamped : target_q;
    // Direction comes from a fresh comparison each update so a retarget can reverse the ramp.
    if (update) begin
      if (target_q > duty_q) begin
        if (step_i == '0 || diff_up <= step_ext) begin
          duty_d  = target_q;
          state_d = StIdle;
        end else begin
          duty_d  = sum_up[Bits_counter-1:0];
          state_d = StUp;
        end
      end else if (target_q < duty_q) begin
        if (step_i == '0 || diff_dn <= step_ext) begin
          duty_d  = target_q;
          state_d = StIdle;
        end else begin
          duty_d  = sum_dn[Bits_counter-1:0];
          state_d = StDown;
        end
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      duty_q      <= '0;
      target_q    <= '0;
      at_target_q <= 1'b1;
      rst_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      target_q    <= target_d;
      at_target_q <= (duty_q == target_q);
      rst_seen_q  <= 1'b1;
    end
  end

  assign duty_cycle_o = duty_q;
  assign at_target_o  = at_target_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp with a queue of expected duty values per update point.
module tb_pwm_duty_ramp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       target_valid;
  logic       target_ready;
  logic [7:0] target_duty;
  logic [7:0] step;
  logic       hold;
  logic [7:0] duty_cycle;
  logic       period_tick;
  logic       at_target;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];

  pwm_duty_ramp #(
    .Bits_counter (8),
    .Periodo      (250)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .target_valid_i (target_valid),
    .target_ready_o (target_ready),
    .target_duty_i  (target_duty),
    .step_i         (step),
    .hold_i         (hold),
    .duty_cycle_o   (duty_cycle),
    .period_tick_o  (period_tick),
    .at_target_o    (at_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: got %0d want %0d", tag, obs, exp_v);
  endtask

  // Cycles from now until period_tick is seen high; -1 if it never shows.
  task automatic count_to_tick(output int n);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (period_tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Advance to just after the next update edge (the edge following a tick).
  task automatic next_update(input string tag);
    int n;
    count_to_tick(n);
    chk({tag, "_tick_seen"}, int'(n > 0), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int t, input int s);
    @(negedge clk);
    target_valid = 1'b1;
    target_duty  = 8'(t);
    step         = 8'(s);
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      next_update(tag);
      chk({tag, "_duty"}, int'(duty_cycle), e);
    end
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    target_valid = 1'b0;
    target_duty  = '0;
    step         = '0;
    hold         = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_duty", int'(duty_cycle), 0);
    chk("rst_at_target", int'(at_target), 1);
    chk("rst_ready", int'(target_ready), 0);
    chk("rst_tick", int'(period_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", int'(target_ready), 1);
    count_to_tick(n);
    chk("first_tick_cycles", n + 1, 250);
    count_to_tick(n);
    chk("tick_period", n, 251);
    chk("idle_duty", int'(duty_cycle), 0);

    // Ramp up 0 -> 100 by 30
    repeat (3) @(posedge clk);
    send(100, 30);
    exp_q.push_back(30);
    exp_q.push_back(60);
    exp_q.push_back(90);
    drain("up100");
    chk("up100_mid_at_target", int'(at_target), 0);
    next_update("up100_last");
    chk("up100_last_duty", int'(duty_cycle), 100);
    chk("up100_at_target_lag", int'(at_target), 0);
    @(posedge clk);
    #1;
    chk("up100_at_target", int'(at_target), 1);

    // Ramp down 100 -> 5 by 40, then clamped jump
    repeat (20) @(posedge clk);
    send(5, 40);
    exp_q.push_back(60);
    exp_q.push_back(20);
    exp_q.push_back(5);
    drain("dn5");
    repeat (20) @(posedge clk);
    send(255, 0);
    exp_q.push_back(250);
    drain("clamp");

    // Mid-ramp reversal
    send(0, 0);
    exp_q.push_back(0);
    drain("zero");
    send(200, 50);
    exp_q.push_back(50);
    exp_q.push_back(100);
    drain("to200");
    repeat (100) @(posedge clk);
    send(20, 50);
    exp_q.push_back(50);
    exp_q.push_back(20);
    drain("rev20");

    // Hold freezes duty for three periods
    repeat (10) @(posedge clk);
    send(200, 60);
    exp_q.push_back(80);
    drain("hold_pre");
    repeat (50) @(posedge clk);
    @(negedge clk);
    hold         = 1'b1;
    target_valid = 1'b1;
    target_duty  = 8'd0;
    #1;
    chk("hold_ready", int'(target_ready), 0);
    for (int k = 0; k < 3; k++) begin
      next_update("hold");
      chk("hold_duty", int'(duty_cycle), 80);
    end
    @(negedge clk);
    hold         = 1'b0;
    target_valid = 1'b0;
    target_duty  = 8'd200;
    #1;
    chk("unhold_ready", int'(target_ready), 1);
    exp_q.push_back(140);
    exp_q.push_back(200);
    drain("unhold");

    // Reset mid-ramp, then accept coinciding with the update edge
    send(0, 50);
    exp_q.push_back(150);
    drain("pre_rst");
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst2_duty", int'(duty_cycle), 0);
    chk("rst2_at_target", int'(at_target), 1);
    chk("rst2_ready", int'(target_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_to_tick(n);
    chk("rst2_tick_cycles", n, 250);
    @(negedge clk);
    target_valid = 1'b1;
    target_duty  = 8'd100;
    step         = 8'd0;
    @(posedge clk);
    #1;
    chk("coincide_duty", int'(duty_cycle), 0);
    @(negedge clk);
    target_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("coincide_at_target", int'(at_target), 0);
    exp_q.push_back(100);
    drain("coincide_next");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
- Upstream stage of the PWM generator: produces its duty_cycle input.
- Accepts a target duty over a valid/ready handshake and slews the output duty toward it by a programmable step, once per PWM period (soft-start / soft-stop for motor and LED loads).
- Keeps its own period counter, matched to the PWM period, so duty changes only at period boundaries and never mid-period.

Parameters:
- Bits_counter, 8: width of duty, step and period counter.
- Periodo, 250: PWM terminal count. Must equal the PWM instance value; one period is Periodo+1 clocks.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- target_valid  in  1  new target duty offered
- target_ready  out  1  block can accept a target this cycle
- target_duty  in  Bits_counter  requested duty, in counts
- step  in  Bits_counter  maximum duty change per period; 0 = jump directly to target
- hold  in  1  freeze ramp; duty held, no targets accepted
- duty_cycle  out  Bits_counter  duty to PWM, registered
- period_tick  out  1  one-clock pulse on the last clock of each period
- at_target  out  1  duty_cycle == latched target, registered

Behaviour:
- Reset (rst_n low at a clk edge), all registers:
  - period counter = 0, duty_cycle = 0, target register = 0
  - state = IDLE, period_tick = 0, at_target = 1, target_ready = 0
  - Reset mid-ramp abandons the ramp; the next cycle starts from duty 0.
- Period counter:
  - Counts 0..Periodo, then wraps to 0.
  - period_tick is registered: high during the cycle the counter holds Periodo.
- Handshake:
  - target_ready = rst_n_registered && !hold, i.e. high from the first cycle after reset release.
  - Transfer occurs when target_valid && target_ready at a clk edge.
  - The target register loads min(target_duty, Periodo); values above Periodo are clamped.
  - A new target replaces the old one at any time, including mid-ramp. Direction is re-evaluated at the next update.
- Update point: the clock edge where the period counter wraps Periodo -> 0, and hold is low. No other edge changes duty_cycle.
- FSM states and transitions (evaluated at the update point):
  - IDLE: duty == target. Go to UP if target > duty; DOWN if target < duty.
  - UP:
    - diff = target - duty, computed in Bits_counter+1 bits.
    - If step == 0 or diff <= step: duty <= target, go to IDLE.
    - Else: duty <= duty + step.
  - DOWN:
    - Mirror of UP: duty <= target if step == 0 or (duty - target) <= step, go to IDLE.
    - Else: duty <= duty - step.
  - A target change can flip UP <-> DOWN directly at the update point; the state is recomputed from the comparison every update.
  - Arithmetic never wraps: sums use Bits_counter+1 bits, and results are bounded by target, which is <= Periodo.
- at_target:
  - Registered; updates the cycle after duty_cycle or the target changes.
  - 1 iff duty_cycle == target.
- hold:
  - The period counter keeps running and period_tick still pulses.
  - duty_cycle is frozen and target_ready = 0.
  - Releasing hold resumes at the next update point.
- Simultaneous target accept and update point on the same edge: the update uses the old target; the new target takes effect at the following period.

Decomposition:
- Shared package: FSM state encoding (IDLE, UP, DOWN) and the period-length constant function (Periodo+1). The PWM stage reuses these.
- Sub-module: pwm_period_timer (counter + period_tick), so the PWM stage can share the identical period definition.

Test Plan (Bits_counter=8, Periodo=250, period = 251 clocks):
- Reset release, no targets -> duty_cycle=0, at_target=1, period_tick every 251 clocks, first tick on the clock where counter=250.
- Target 100, step 30 -> duty 30, 60, 90, 100 at successive update points, then IDLE; at_target=1 one cycle after duty reaches 100.
- From 100, target 5, step 40 -> duty 60, 20, 5. Then target 255 with step 0 -> clamped, duty jumps to 250 in one update.
- Mid-ramp reversal: ramp toward 200 step 50 at duty 100, new target 20 accepted mid-period -> next updates 50, 20.
- hold asserted for 3 periods during a ramp -> duty unchanged, target_ready=0, ticks continue; after release the ramp resumes one step per period.
- rst_n low for 1 clock during a ramp at duty 150 -> next cycle duty=0, counter=0, state IDLE, target=0; accept on the same edge as the update point applies one period later.
